rider_load_mon: RTL and testbench

Rider load monitor: front end that produces the condition flags consumed by the steering-enable state machine. Captures left/right load-cell readings when the A2D interface strobes them and registers the sum, difference and threshold comparisons. Also owns the 1.3 s rider-settle timer, which the state machine clears through `clr_tmr`. A staleness watchdog reports the rider as off if load-cell updates stop.

---
 rtl/rider_load_mon_if.sv | 23 ++
 rtl/rider_load_mon.sv | 106 ++++++++++
 tb/tb_rider_load_mon.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/rider_load_mon_if.sv
// Load-cell sample strobe, settle-timer clear and the registered condition
// flags exchanged between the A2D front end / steering FSM and rider_load_mon.
interface rider_load_mon_if;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic        ld_vld;
  logic        clr_tmr;
  logic        sum_gt_min;
  logic        sum_lt_min;
  logic        diff_gt_1_4;
  logic        diff_gt_15_16;
  logic        tmr_full;

  modport master (
    output lft_ld, rght_ld, ld_vld, clr_tmr,
    input  sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16, tmr_full
  );

  modport slave (
    input  lft_ld, rght_ld, ld_vld, clr_tmr,
    output sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16, tmr_full
  );
endinterface

// File: rtl/rider_load_mon.sv
// Rider load monitor: captures load-cell pairs, registers weight/balance flags,
// runs the rider-settle timer and forces "rider off" when samples go stale.
module rider_load_mon #(
  parameter logic [11:0] MIN_RIDER_WT = 12'h200,
  parameter logic [11:0] WT_HYST      = 12'h040,
  parameter logic [25:0] TMR_FULL_CNT = 26'd65_000_000,
  parameter logic [20:0] STALE_CYC    = 21'd1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  rider_load_mon_if.slave   bus
);

  localparam logic [12:0] THR_HI = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYST};
  localparam logic [12:0] THR_LO = (MIN_RIDER_WT > WT_HYST) ?
                                   {1'b0, MIN_RIDER_WT - WT_HYST} : 13'd0;

  logic [11:0] r_lft_q;
  logic [11:0] r_rght_q;
  logic [20:0] r_stale_cnt;
  logic [25:0] r_tmr_cnt;
  logic        r_sum_gt_min;
  logic        r_sum_lt_min;
  logic        r_diff_gt_1_4;
  logic        r_diff_gt_15_16;

  logic [12:0] w_sum;
  logic [11:0] w_diff;
  logic [10:0] w_quarter;
  logic [12:0] w_ff16;
  logic        w_stale;
  logic        w_gt_min;
  logic        w_lt_min;
  logic        w_gt_1_4;
  logic        w_gt_15_16;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lft_q  <= '0;
      r_rght_q <= '0;
    end else if (bus.ld_vld) begin
      r_lft_q  <= bus.lft_ld;
      r_rght_q <= bus.rght_ld;
    end
  end

  assign w_sum     = {1'b0, r_lft_q} + {1'b0, r_rght_q};
  assign w_diff    = (r_lft_q >= r_rght_q) ? (r_lft_q - r_rght_q) : (r_rght_q - r_lft_q);
  assign w_quarter = w_sum[12:2];
  // 15*sum needs 17 bits; floor of the /16 keeps the upper 13
  assign w_ff16    = 13'((17'(w_sum) * 17'd15) >> 4);

  assign w_gt_min   = (w_sum > THR_HI);
  assign w_lt_min   = (w_sum < THR_LO);
  assign w_gt_1_4   = (w_sum != 13'd0) && (w_diff > {1'b0, w_quarter});
  assign w_gt_15_16 = (w_sum != 13'd0) && ({1'b0, w_diff} > w_ff16);

  assign w_stale = (r_stale_cnt == STALE_CYC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stale_cnt <= '0;
    end else if (bus.ld_vld) begin
      r_stale_cnt <= '0;
    end else if (!w_stale) begin
      r_stale_cnt <= r_stale_cnt + 21'd1;
    end
  end

  // Stale samples look like an empty platform so the FSM drops steering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_gt_min    <= 1'b0;
      r_sum_lt_min    <= 1'b0;
      r_diff_gt_1_4   <= 1'b0;
      r_diff_gt_15_16 <= 1'b0;
    end else if (w_stale) begin
      r_sum_gt_min    <= 1'b0;
      r_sum_lt_min    <= 1'b1;
      r_diff_gt_1_4   <= 1'b0;
      r_diff_gt_15_16 <= 1'b0;
    end else begin
      r_sum_gt_min    <= w_gt_min;
      r_sum_lt_min    <= w_lt_min;
      r_diff_gt_1_4   <= w_gt_1_4;
      r_diff_gt_15_16 <= w_gt_15_16;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr_cnt <= '0;
    end else if (bus.clr_tmr) begin
      r_tmr_cnt <= '0;
    end else if (r_tmr_cnt != TMR_FULL_CNT) begin
      r_tmr_cnt <= r_tmr_cnt + 26'd1;
    end
  end

  assign bus.sum_gt_min    = r_sum_gt_min;
  assign bus.sum_lt_min    = r_sum_lt_min;
  assign bus.diff_gt_1_4   = r_diff_gt_1_4;
  assign bus.diff_gt_15_16 = r_diff_gt_15_16;
  assign bus.tmr_full      = (r_tmr_cnt == TMR_FULL_CNT);

endmodule

// File: tb/tb_rider_load_mon.sv
// Self-checking bench for rider_load_mon: vector table, timer/stale/reset
// sequences and a randomized run against a cycle-level behavioural model.
module tb_rider_load_mon;
  localparam int TMR_N   = 100;
  localparam int STALE_N = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rider_load_mon_if bus();

  rider_load_mon #(
    .MIN_RIDER_WT (12'h200),
    .WT_HYST      (12'h040),
    .TMR_FULL_CNT (26'd100),
    .STALE_CYC    (21'd50)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model state: last captured pair, clocks since last strobe, clocks since clear
  int m_l, m_r, m_since, m_tmr;
  logic [4:0] m_out;  // {gt, lt, d14, d1516, full}

  typedef struct {
    int l;
    int r;
    logic [3:0] exp;  // {gt, lt, d14, d1516}
  } vec_t;
  vec_t vecs[8];

  function automatic logic [3:0] weigh(input int l, input int r);
    int s;
    int d;
    logic [3:0] f;
    s = l + r;
    d = (l > r) ? l - r : r - l;
    f[3] = (s > 'h240);
    f[2] = (s < 'h1C0);
    f[1] = (s != 0) && (d > s / 4);
    f[0] = (s != 0) && (d > (15 * s) / 16);
    return f;
  endfunction

  function automatic logic [4:0] dut_out();
    return {bus.sum_gt_min, bus.sum_lt_min, bus.diff_gt_1_4, bus.diff_gt_15_16, bus.tmr_full};
  endfunction

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_l = 0; m_r = 0; m_since = 0; m_tmr = 0; m_out = '0;
  endtask

  // One clock: drive at negedge, model advances at posedge, compare at next negedge
  task automatic step(input logic vld, input int l, input int r, input logic clr);
    bus.ld_vld  = vld;
    bus.lft_ld  = l[11:0];
    bus.rght_ld = r[11:0];
    bus.clr_tmr = clr;
    @(posedge clk);
    m_out[4:1] = (m_since >= STALE_N) ? 4'b0100 : weigh(m_l, m_r);
    m_tmr      = clr ? 0 : ((m_tmr < TMR_N) ? m_tmr + 1 : m_tmr);
    m_out[0]   = (m_tmr >= TMR_N);
    m_since    = vld ? 0 : ((m_since < STALE_N) ? m_since + 1 : m_since);
    if (vld) begin
      m_l = l;
      m_r = r;
    end
    @(negedge clk);
    chk("model", dut_out(), m_out);
  endtask

  function automatic int rnd_ld();
    case ($urandom_range(0, 2))
      0:       return int'($urandom_range(0, 4095));
      1:       return int'($urandom_range('hC0, 'h140));
      default: return int'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    vecs[0] = '{l: 'h100, r: 'h100, exp: 4'b0000};
    vecs[1] = '{l: 'h120, r: 'h120, exp: 4'b0000};
    vecs[2] = '{l: 'h0F0, r: 'h0F0, exp: 4'b0000};
    vecs[3] = '{l: 'h0D0, r: 'h0D0, exp: 4'b0100};
    vecs[4] = '{l: 'h300, r: 'h1C0, exp: 4'b1010};
    vecs[5] = '{l: 'h7F0, r: 'h010, exp: 4'b1011};
    vecs[6] = '{l: 'h000, r: 'h000, exp: 4'b0100};
    vecs[7] = '{l: 'h005, r: 'h000, exp: 4'b0111};

    bus.ld_vld = 1'b0; bus.lft_ld = '0; bus.rght_ld = '0; bus.clr_tmr = 1'b0;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", dut_out(), 5'b00000);
    rst_n = 1'b1;
    step(1'b0, 0, 0, 1'b0);
    chk1("post_reset_lt", bus.sum_lt_min, 1'b1);

    // Vector table: strobe, then check two clocks after the strobe
    for (int i = 0; i < 8; i++) begin
      step(1'b1, vecs[i].l, vecs[i].r, 1'b0);
      step(1'b0, 0, 0, 1'b0);
      chk($sformatf("vec%0d", i), {1'b0, dut_out()[4:1]}, {1'b0, vecs[i].exp});
      $display("vec %0d l=%03h r=%03h flags=%b", i, vecs[i].l, vecs[i].r, dut_out()[4:1]);
    end

    // Timer: full exactly TMR_N clocks after clear, then holds
    step(1'b0, 0, 0, 1'b1);
    for (int i = 1; i < TMR_N; i++) step(1'b0, 0, 0, 1'b0);
    chk1("tmr_not_yet", bus.tmr_full, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    chk1("tmr_full_rise", bus.tmr_full, 1'b1);
    repeat (5) step(1'b0, 0, 0, 1'b0);
    chk1("tmr_full_hold", bus.tmr_full, 1'b1);
    step(1'b0, 0, 0, 1'b1);
    chk1("tmr_clr_when_full", bus.tmr_full, 1'b0);
    for (int i = 0; i < 60; i++) step(1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b1);
    for (int i = 1; i < TMR_N; i++) step(1'b0, 0, 0, 1'b0);
    chk1("tmr_reclr_not_yet", bus.tmr_full, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    chk1("tmr_reclr_full", bus.tmr_full, 1'b1);
    $display("timer sequence done");

    // Staleness: forced flags appear STALE_N+1 clocks after the last strobe
    step(1'b1, 'h300, 'h300, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    chk1("stale_gt_early", bus.sum_gt_min, 1'b1);
    for (int k = 2; k <= STALE_N; k++) step(1'b0, 0, 0, 1'b0);
    chk1("stale_gt_last", bus.sum_gt_min, 1'b1);
    step(1'b0, 0, 0, 1'b0);
    chk("stale_forced", {1'b0, dut_out()[4:1]}, 5'b00100);
    step(1'b1, 'h300, 'h300, 1'b0);
    chk1("stale_at_strobe", bus.sum_lt_min, 1'b1);
    step(1'b0, 0, 0, 1'b0);
    chk1("stale_recover_gt", bus.sum_gt_min, 1'b1);
    chk1("stale_recover_lt", bus.sum_lt_min, 1'b0);
    $display("stale sequence done");

    // Reset mid-operation with timer at 80 and rider present
    step(1'b1, 'h300, 'h300, 1'b1);
    for (int i = 1; i <= 80; i++) step((i % 20) == 0, 'h300, 'h300, 1'b0);
    chk1("pre_reset_gt", bus.sum_gt_min, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", dut_out(), 5'b00000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i < TMR_N; i++) step(1'b0, 0, 0, 1'b0);
    chk1("tmr_after_reset_not_yet", bus.tmr_full, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    chk1("tmr_after_reset_full", bus.tmr_full, 1'b1);
    $display("reset sequence done");

    // Randomized run against the model, with occasional long gaps to go stale
    begin
      int gap;
      int errs0;
      gap = 0;
      errs0 = errors;
      for (int i = 0; i < 1500; i++) begin
        logic vld;
        vld = (gap == 0);
        if (vld) gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(40, 70))
                                                   : int'($urandom_range(0, 6));
        else gap--;
        step(vld, rnd_ld(), rnd_ld(), $urandom_range(0, 59) == 0);
      end
      $display("random run: 1500 cycles, %0d new errors", errors - errs0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
